// File: rtl/mem_stage_pipe_if.sv
// mem_stage_pipe_if: E-stage bundle in, M-stage bundle out, plus hazard-unit StallM/FlushM/MemBusyM/MisalignM
interface mem_stage_pipe_if #(parameter int WIDTH = 32);
  logic StallM, FlushM;
  logic RegWriteE, MemWriteE, MemReadE, LdUnsignedE;
  logic [1:0] ResultSrcE, SizeE;
  logic [WIDTH-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0] RdE;
  logic RegWriteM;
  logic [1:0] ResultSrcM;
  logic [4:0] RdM;
  logic [WIDTH-1:0] ALUResultM, PCPlus4M, ReadDataM;
  logic MemBusyM, MisalignM;
  modport master(
    output StallM, FlushM, RegWriteE, MemWriteE, MemReadE, LdUnsignedE, ResultSrcE, SizeE,
           ALUResultE, WriteDataE, PCPlus4E, RdE,
    input  RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M, ReadDataM, MemBusyM, MisalignM
  );
  modport slave(
    input  StallM, FlushM, RegWriteE, MemWriteE, MemReadE, LdUnsignedE, ResultSrcE, SizeE,
           ALUResultE, WriteDataE, PCPlus4E, RdE,
    output RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M, ReadDataM, MemBusyM, MisalignM
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: EX/MEM register + wait-stated byte/half/word data memory; ports clk, rst_n (sync active-low), bus (slave)
module mem_stage_pipe #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_LATENCY = 0
) (
  input logic clk,
  input logic rst_n,
  mem_stage_pipe_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic reg_write, mem_write, mem_read, ld_unsigned, done;
  logic [1:0] result_src, size, state;
  logic [2:0] cnt;
  logic [4:0] rd;
  logic [WIDTH-1:0] alu_result, write_data, pc_plus4;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] ai [4];
  logic [7:0] rb [4];
  logic [3:0] lanes;
  logic advance, misalign, commit, sext;
  always_comb begin
    addr = alu_result[ADDR_WIDTH-1:0];
    misalign = (mem_read | mem_write) && (size == 2'b01 ? addr[0] : size[1] && addr[1:0] != 2'b00);
    lanes = size == 2'b00 ? 4'b0001 : size == 2'b01 ? 4'b0011 : 4'b1111;
    advance = !bus.StallM && state != WAIT;
    commit = rst_n && !bus.FlushM && state == DONE && mem_write && !done && !misalign;
    sext = !ld_unsigned;
    for (int i = 0; i < 4; i++) begin
      ai[i] = addr + ADDR_WIDTH'(i);
      rb[i] = mem[ai[i]];
    end
  end
  assign bus.RegWriteM = reg_write;
  assign bus.ResultSrcM = result_src;
  assign bus.RdM = rd;
  assign bus.ALUResultM = alu_result;
  assign bus.PCPlus4M = pc_plus4;
  assign bus.MemBusyM = state == WAIT;
  assign bus.MisalignM = misalign;
  assign bus.ReadDataM = (!mem_read || misalign) ? '0 :
                         size == 2'b00 ? {{(WIDTH-8){sext & rb[0][7]}}, rb[0]} :
                         size == 2'b01 ? {{(WIDTH-16){sext & rb[1][7]}}, rb[1], rb[0]} :
                         WIDTH'({rb[3], rb[2], rb[1], rb[0]});
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      ld_unsigned <= 1'b0;
      result_src <= '0;
      size <= '0;
      rd <= '0;
      alu_result <= '0;
      write_data <= '0;
      pc_plus4 <= '0;
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
    end else if (bus.FlushM) begin
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      result_src <= '0;
      state <= IDLE;
      done <= 1'b0;
    end else if (advance) begin
      reg_write <= bus.RegWriteE;
      mem_write <= bus.MemWriteE;
      mem_read <= bus.MemReadE;
      ld_unsigned <= bus.LdUnsignedE;
      result_src <= bus.ResultSrcE;
      size <= bus.SizeE;
      rd <= bus.RdE;
      alu_result <= bus.ALUResultE;
      write_data <= bus.WriteDataE;
      pc_plus4 <= bus.PCPlus4E;
      state <= (bus.MemReadE | bus.MemWriteE) ? (MEM_LATENCY > 0 ? WAIT : DONE) : IDLE;
      cnt <= 3'(MEM_LATENCY - 1);
      done <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt - 3'd1;
      state <= cnt == 3'd0 ? DONE : WAIT;
    end else if (commit) begin
      done <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (commit)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mem[ai[i]] <= write_data[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks of mem_stage_pipe at MEM_LATENCY 0, 3 and 4 driven from one shared stimulus
module tb_mem_stage_pipe;
  logic clk = 1'b0;
  logic rst_n, stall, flush, rw, mw, mr, lu;
  logic [1:0] rs, sz;
  logic [31:0] alu, wd, pc;
  logic [4:0] rd;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_stage_pipe_if #(.WIDTH(32)) b[3] ();
  for (genvar g = 0; g < 3; g++) begin : gen
    assign b[g].StallM = stall;
    assign b[g].FlushM = flush;
    assign b[g].RegWriteE = rw;
    assign b[g].MemWriteE = mw;
    assign b[g].MemReadE = mr;
    assign b[g].LdUnsignedE = lu;
    assign b[g].ResultSrcE = rs;
    assign b[g].SizeE = sz;
    assign b[g].ALUResultE = alu;
    assign b[g].WriteDataE = wd;
    assign b[g].PCPlus4E = pc;
    assign b[g].RdE = rd;
    mem_stage_pipe #(.WIDTH(32), .ADDR_WIDTH(12), .MEM_LATENCY(g == 0 ? 0 : g + 2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic st, input logic ld, input logic u, input logic [1:0] s,
                    input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    mw = st; mr = ld; lu = u; sz = s; alu = a; wd = d; rd = r;
    rw = ld; rs = {1'b0, ld}; pc = a + 32'h100;
  endtask
  task automatic do_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    op(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
    step;
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1; rw = 1'b1; mw = 1'b1; mr = 1'b1; lu = 1'b1;
    rs = '1; sz = '1; alu = '1; wd = '1; pc = '1; rd = '1;
    step;
    chk("rst_regwrite", b[0].RegWriteM, 0);
    chk("rst_resultsrc", b[0].ResultSrcM, 0);
    chk("rst_rd", b[0].RdM, 0);
    chk("rst_alu", b[0].ALUResultM, 0);
    chk("rst_pc", b[0].PCPlus4M, 0);
    chk("rst_rdata", b[0].ReadDataM, 0);
    chk("rst_busy", b[0].MemBusyM, 0);
    chk("rst_mis", b[0].MisalignM, 0);
    chk("rst_busy_l3", b[1].MemBusyM, 0);
    do_reset;
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 5'd0); step;
    chk("sw_l0_busy", b[0].MemBusyM, 0);
    op(1'b0, 1'b1, 1'b0, 2'd0, 32'h13, 32'h0, 5'd5); step;
    chk("lb", b[0].ReadDataM, 32'hFFFFFFDE);
    chk("lb_rd", b[0].RdM, 5);
    chk("lb_rs", b[0].ResultSrcM, 1);
    op(1'b0, 1'b1, 1'b1, 2'd0, 32'h13, 32'h0, 5'd5); step;
    chk("lbu", b[0].ReadDataM, 32'h000000DE);
    op(1'b0, 1'b1, 1'b0, 2'd1, 32'h12, 32'h0, 5'd5); step;
    chk("lh", b[0].ReadDataM, 32'hFFFFDEAD);
    op(1'b0, 1'b1, 1'b1, 2'd1, 32'h12, 32'h0, 5'd5); step;
    chk("lhu", b[0].ReadDataM, 32'h0000DEAD);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 5'd5); step;
    chk("lw", b[0].ReadDataM, 32'hDEADBEEF);
    op(1'b0, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 5'd5); step;
    chk("lb_lo", b[0].ReadDataM, 32'hFFFFFFEF);
    op(1'b0, 1'b0, 1'b0, 2'd0, 32'h77, 32'h0, 5'd4); rw = 1'b1; step;
    chk("alu_pass", b[0].ALUResultM, 32'h77);
    chk("alu_regwrite", b[0].RegWriteM, 1);
    chk("alu_rdata", b[0].ReadDataM, 0);
    chk("alu_busy", b[0].MemBusyM, 0);
    do_reset;
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'hCAFEF00D, 5'd3); step;
    chk("l3_sw_busy", b[1].MemBusyM, 1);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h99, 32'h0, 5'd7);
    for (int i = 1; i < 3; i++) begin step; chk("l3_sw_busy", b[1].MemBusyM, 1); end
    step;
    chk("l3_sw_free", b[1].MemBusyM, 0);
    chk("l3_hold_alu", b[1].ALUResultM, 32'h40);
    chk("l3_hold_rd", b[1].RdM, 3);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 5'd9); step;
    chk("l3_lw_busy", b[1].MemBusyM, 1);
    for (int i = 1; i < 3; i++) begin step; chk("l3_lw_busy", b[1].MemBusyM, 1); end
    step;
    chk("l3_lw_free", b[1].MemBusyM, 0);
    chk("l3_lw_data", b[1].ReadDataM, 32'hCAFEF00D);
    chk("l3_lw_rd", b[1].RdM, 9);
    do_reset;
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h11223344, 5'd0); step;
    op(1'b1, 1'b0, 1'b0, 2'd1, 32'h21, 32'h1234, 5'd0); step;
    chk("sh_mis", b[0].MisalignM, 1);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0, 5'd1); step;
    chk("mis_word", b[0].ReadDataM, 32'h11223344);
    chk("mis_clear", b[0].MisalignM, 0);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h22, 32'h0, 5'd1); step;
    chk("lw_mis_data", b[0].ReadDataM, 0);
    chk("lw_mis_flag", b[0].MisalignM, 1);
    op(1'b0, 1'b1, 1'b0, 2'd1, 32'h22, 32'h0, 5'd1); step;
    chk("lh_22", b[0].ReadDataM, 32'h00001122);
    op(1'b1, 1'b0, 1'b0, 2'd0, 32'h30, 32'h55, 5'd0); step;
    stall = 1'b1; step;
    chk("sb_commit", gen[0].dut.mem[12'h30], 32'h55);
    gen[0].dut.mem[12'h30] = 8'h00;
    for (int i = 0; i < 4; i++) begin step; chk("stall_hold", b[0].ALUResultM, 32'h30); end
    stall = 1'b0;
    op(1'b0, 1'b1, 1'b1, 2'd0, 32'h30, 32'h0, 5'd2); step;
    chk("sb_once", b[0].ReadDataM, 0);
    do_reset;
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h54, 32'h01020304, 5'd0); step;
    repeat (4) step;
    chk("f_ready", b[2].MemBusyM, 0);
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h54, 32'hFFFFFFFF, 5'd6); rw = 1'b1; step;
    chk("f_busy", b[2].MemBusyM, 1);
    chk("f_rw", b[2].RegWriteM, 1);
    flush = 1'b1;
    op(1'b0, 1'b0, 1'b0, 2'd0, 32'h88, 32'h0, 5'd0); step;
    flush = 1'b0;
    chk("f_rw_clr", b[2].RegWriteM, 0);
    chk("f_pc_hold", b[2].PCPlus4M, 32'h154);
    step;
    chk("f_busy_clr", b[2].MemBusyM, 0);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h54, 32'h0, 5'd1); step;
    repeat (4) step;
    chk("f_word", b[2].ReadDataM, 32'h01020304);
    do_reset;
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h1004, 32'hA5A5A5A5, 5'd0); step;
    chk("wrap_alu", b[0].ALUResultM, 32'h1004);
    op(1'b0, 1'b1, 1'b0, 2'd2, 32'h4, 32'h0, 5'd1); step;
    chk("wrap_rd", b[0].ReadDataM, 32'hA5A5A5A5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
